branch_resolve: RTL and testbench

Resolves branches and jumps in the CPU execute stage. It consumes the `a_lt_b` / `a_eq_b` flags from the branch comparator, computes the architectural outcome and target, and compares them with the fetch-stage prediction. On a misprediction it issues a redirect to fetch through a valid/ready handshake, then holds a pipeline flush for a fixed number of cycles.

---
 rtl/branch_resolve_if.sv | 40 ++++
 rtl/branch_resolve.sv | 134 +++++++++++++
 tb/tb_branch_resolve.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// Execute-stage branch resolution bus: instruction in, redirect/link/exception out.
// Redirect handshake: a transfer happens on a rising clk edge where redirect_valid && redirect_ready; once raised, redirect_valid and redirect_pc hold until that edge.
interface branch_resolve_if;
    logic        in_valid;
    logic        in_ready;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        pred_taken;
    logic        cmp_unsigned;
    logic        a_lt_b;
    logic        a_eq_b;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        flush;
    logic        link_valid;
    logic [31:0] link_addr;
    logic        misaligned;
    logic        illegal;
    logic [1:0]  state_dbg;

    modport master (
        output in_valid, is_branch, is_jal, is_jalr, funct3, pc, imm, rs1,
               pred_taken, a_lt_b, a_eq_b, redirect_ready,
        input  in_ready, cmp_unsigned, redirect_valid, redirect_pc, flush,
               link_valid, link_addr, misaligned, illegal, state_dbg
    );

    modport slave (
        input  in_valid, is_branch, is_jal, is_jalr, funct3, pc, imm, rs1,
               pred_taken, a_lt_b, a_eq_b, redirect_ready,
        output in_ready, cmp_unsigned, redirect_valid, redirect_pc, flush,
               link_valid, link_addr, misaligned, illegal, state_dbg
    );
endinterface

// File: rtl/branch_resolve.sv
// Branch/jump resolution: outcome vs prediction, redirect handshake, timed flush.
// Optional BRANCH_STATS_EN adds saturating branch and mispredict counters.
module branch_resolve #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    branch_resolve_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  flush_cnt;
    logic        cond_met;
    logic        br_illegal;
    logic        is_jump;
    logic        taken;
    logic        mis;
    logic        need_redirect;
    logic        accept;
    logic [31:0] fall_pc;
    logic [31:0] br_target;
    logic [31:0] jalr_target;
    logic [31:0] next_pc;

    assign bus.cmp_unsigned = bus.funct3[1];
    assign bus.in_ready     = (state == IDLE);
    assign bus.state_dbg    = state;
    assign accept           = bus.in_valid && (state == IDLE);

    always_comb begin
        cond_met = 1'b0;
        case (bus.funct3)
            3'b000:         cond_met = bus.a_eq_b;
            3'b001:         cond_met = !bus.a_eq_b;
            3'b100, 3'b110: cond_met = bus.a_lt_b;
            3'b101, 3'b111: cond_met = !bus.a_lt_b;
            default:        cond_met = 1'b0;
        endcase
    end

    assign fall_pc     = bus.pc + 32'd4;
    assign br_target   = bus.pc + bus.imm;
    assign jalr_target = (bus.rs1 + bus.imm) & ~32'd1;
    assign br_illegal  = bus.is_branch && (bus.funct3[2:1] == 2'b01);
    assign is_jump     = bus.is_jal || bus.is_jalr;
    assign taken       = is_jump || (bus.is_branch && !br_illegal && cond_met);
    assign next_pc     = bus.is_jalr ? jalr_target : (taken ? br_target : fall_pc);
    // A misaligned target raises an exception instead of redirecting fetch.
    assign mis         = (is_jump || (bus.is_branch && !br_illegal)) && next_pc[1];
    assign need_redirect = !mis &&
        (is_jump || (bus.is_branch && !br_illegal && (taken != bus.pred_taken)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            flush_cnt          <= 4'd0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= 32'd0;
            bus.flush          <= 1'b0;
            bus.link_valid     <= 1'b0;
            bus.link_addr      <= 32'd0;
            bus.misaligned     <= 1'b0;
            bus.illegal        <= 1'b0;
        end else begin
            bus.link_valid <= 1'b0;
            bus.misaligned <= 1'b0;
            bus.illegal    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.link_valid <= is_jump;
                        bus.misaligned <= mis;
                        bus.illegal    <= br_illegal;
                        if (is_jump) bus.link_addr <= fall_pc;
                        if (need_redirect) begin
                            bus.redirect_valid <= 1'b1;
                            bus.redirect_pc    <= next_pc;
                            state              <= REDIRECT;
                        end
                    end
                end
                REDIRECT: begin
                    if (bus.redirect_ready) begin
                        bus.redirect_valid <= 1'b0;
                        if (FLUSH_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            bus.flush <= 1'b1;
                            flush_cnt <= 4'(FLUSH_CYCLES);
                            state     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'd1) begin
                        bus.flush <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: begin
                    bus.redirect_valid <= 1'b0;
                    bus.flush          <= 1'b0;
                    state              <= IDLE;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else if (accept && bus.is_branch) begin
            if (stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (need_redirect && stat_mispredicts != 32'hFFFF_FFFF)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// Randomized + directed bench for branch_resolve with a response scoreboard.
module tb_branch_resolve;
  localparam int FC = 2;
  localparam int W  = 68;  // {redirect, redirect_pc, link, link_addr, misaligned, illegal}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_if bus();
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_resolve #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] exp_br = 0;
  logic [31:0] exp_mp = 0;
  int rr_mode = 0;  // 0: ready high, 1: random, 2: held low

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural rules evaluated on the raw operands.
  function automatic void model(input int cls, input logic [2:0] f3,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic [31:0] a,
                                input logic [31:0] b, input logic pred,
                                output logic [W-1:0] e, output bit has, output bit br_redir);
    logic [31:0] nxt;
    bit rd, lk, mis, ill, tk, ctrl;
    nxt = pc + 32'd4;
    rd = 0; lk = 0; mis = 0; ill = 0; tk = 0; ctrl = (cls != 0);
    if (cls == 2) begin
      nxt = pc + imm; rd = 1; lk = 1;
    end else if (cls == 3) begin
      nxt = (rs1 + imm) & 32'hFFFF_FFFE; rd = 1; lk = 1;
    end else if (cls == 1) begin
      case (f3)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = ($signed(a) < $signed(b));
        3'd5: tk = ($signed(a) >= $signed(b));
        3'd6: tk = (a < b);
        3'd7: tk = (a >= b);
        default: ill = 1;
      endcase
      if (tk) nxt = pc + imm;
      rd = !ill && (tk != pred);
    end
    if (ctrl && !ill && nxt[1]) begin
      mis = 1; rd = 0;
    end
    br_redir = (cls == 1) && rd;
    has = rd || lk || mis || ill;
    e = {rd, rd ? nxt : 32'd0, lk, lk ? pc + 32'd4 : 32'd0, mis, ill};
  endfunction

  task automatic issue(input int cls, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1,
                       input logic [31:0] a, input logic [31:0] b, input logic pred);
    int n;
    logic [W-1:0] e;
    bit has, brr;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      check1("in_ready_timeout", bus.in_ready, 1'b1);
      return;
    end
    bus.is_branch  = (cls == 1);
    bus.is_jal     = (cls == 2);
    bus.is_jalr    = (cls == 3);
    bus.funct3     = f3;
    bus.pc         = pc;
    bus.imm        = imm;
    bus.rs1        = rs1;
    bus.pred_taken = pred;
    bus.a_eq_b     = (a == b);
    bus.a_lt_b     = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    bus.in_valid   = 1'b1;
    #1;
    check1("cmp_unsigned", bus.cmp_unsigned, f3[1]);
    model(cls, f3, pc, imm, rs1, a, b, pred, e, has, brr);
    if (has) exp_q.push_back(e);
    if (cls == 1) begin
      exp_br++;
      if (brr) exp_mp++;
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.is_branch = 1'b0;
    bus.is_jal    = 1'b0;
    bus.is_jalr   = 1'b0;
  endtask

  task automatic do_reset(input bit chk);
    rst = 1'b1;
    exp_q.delete();
    exp_br = 0;
    exp_mp = 0;
    #1;
    if (chk) begin
      check1("rst_flush", bus.flush, 1'b0);
      check1("rst_in_ready", bus.in_ready, 1'b1);
      check1("rst_redirect_valid", bus.redirect_valid, 1'b0);
    end
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check1("drain", (exp_q.size() == 0) && bus.in_ready, 1'b1);
  endtask

  // Redirect-ready driver.
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0: bus.redirect_ready = 1'b1;
      1: bus.redirect_ready = 1'($urandom_range(0, 1));
      default: bus.redirect_ready = 1'b0;
    endcase
  end

  // Monitor: pops expected responses and tracks the redirect/flush window.
  bit rv_exp = 0;
  bit hs_pend = 0;
  int flush_left = 0;
  logic [31:0] held_pc = 0;
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    if (rst) begin
      rv_exp = 0; hs_pend = 0; flush_left = 0;
    end else begin
      if (hs_pend) begin
        hs_pend = 0; flush_left = FC;
      end
      if (bus.link_valid || bus.misaligned || bus.illegal || (bus.redirect_valid && !rv_exp)) begin
        act = {bus.redirect_valid, bus.redirect_valid ? bus.redirect_pc : 32'd0,
               bus.link_valid, bus.link_valid ? bus.link_addr : 32'd0,
               bus.misaligned, bus.illegal};
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_response: got %0h expected none at %0t", act, $time);
        end else begin
          e = exp_q.pop_front();
          checkw("response", act, e);
          if (e[67]) begin
            rv_exp = 1; held_pc = e[66:35];
          end
        end
      end
      if (rv_exp) begin
        check1("redirect_valid_held", bus.redirect_valid, 1'b1);
        check32("redirect_pc_stable", bus.redirect_pc, held_pc);
        check1("in_ready_in_redirect", bus.in_ready, 1'b0);
        check1("flush_in_redirect", bus.flush, 1'b0);
        if (bus.redirect_ready) begin
          rv_exp = 0; hs_pend = 1;
        end
      end else if (flush_left > 0) begin
        check1("flush_high", bus.flush, 1'b1);
        check1("in_ready_in_flush", bus.in_ready, 1'b0);
        check1("redirect_valid_in_flush", bus.redirect_valid, 1'b0);
        flush_left--;
      end else begin
        check1("flush_idle", bus.flush, 1'b0);
        check1("redirect_valid_idle", bus.redirect_valid, 1'b0);
        check1("in_ready_idle", bus.in_ready, 1'b1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    int n;
    bus.in_valid = 0; bus.is_branch = 0; bus.is_jal = 0; bus.is_jalr = 0;
    bus.funct3 = 0; bus.pc = 0; bus.imm = 0; bus.rs1 = 0; bus.pred_taken = 0;
    bus.a_lt_b = 0; bus.a_eq_b = 0; bus.redirect_ready = 1;
    #2;
    check1("reset_in_ready", bus.in_ready, 1'b1);
    check1("reset_redirect_valid", bus.redirect_valid, 1'b0);
    check1("reset_flush", bus.flush, 1'b0);
    check1("reset_link_valid", bus.link_valid, 1'b0);
    check1("reset_misaligned", bus.misaligned, 1'b0);
    check1("reset_illegal", bus.illegal, 1'b0);
    check32("reset_redirect_pc", bus.redirect_pc, 32'd0);
    check32("reset_link_addr", bus.link_addr, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    // Mispredicted BEQ, immediate handshake.
    rr_mode = 0;
    issue(1, 3'b000, 32'h100, 32'h20, 0, 32'd7, 32'd7, 1'b0);
    // Correctly predicted BLTU, back-to-back with a non-control op.
    drain();
    issue(1, 3'b110, 32'h200, 32'h40, 0, 32'd1, 32'hFFFF_FFF0, 1'b1);
    check1("in_ready_after_predicted", bus.in_ready, 1'b1);
    issue(0, 3'b000, 32'h204, 0, 0, 0, 0, 1'b0);
    // JALR to a misaligned target, then JALR with redirect held off for 3 cycles.
    issue(3, 3'b000, 32'h300, 32'h0, 32'h1003, 0, 0, 1'b0);
    rr_mode = 2;
    issue(3, 3'b000, 32'h304, 32'h0, 32'h1001, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rr_mode = 0;
    drain();
    // BNE target wraps past 2^32; illegal funct3.
    issue(1, 3'b001, 32'hFFFF_FFFC, 32'h8, 0, 32'd1, 32'd2, 1'b0);
    issue(1, 3'b010, 32'h400, 32'h10, 0, 32'd1, 32'd1, 1'b1);
    // Taken branch to pc+2.
    issue(1, 3'b000, 32'h100, 32'h2, 0, 32'd5, 32'd5, 1'b1);
    drain();
    // Reset while flushing.
    issue(2, 3'b000, 32'h500, 32'h80, 0, 0, 0, 1'b0);
    n = 0;
    while (!bus.flush && n < 20) begin
      @(negedge clk); n++;
    end
    check1("reached_flush", bus.flush, 1'b1);
    #2;
    do_reset(1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      int cls;
      logic [2:0] f3;
      logic [31:0] pc, imm, rs1, a, b;
      cls = $urandom_range(0, 3);
      f3  = 3'($urandom_range(0, 7));
      pc  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) pc = pc | 32'h2;
      imm = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      rs1 = $urandom;
      a   = $urandom;
      b   = ($urandom_range(0, 2) == 0) ? a : $urandom;
      rr_mode = ($urandom_range(0, 2) == 0) ? 0 : 1;
      issue(cls, f3, pc, imm, rs1, a, b, 1'($urandom_range(0, 1)));
    end
    rr_mode = 0;
    drain();

`ifdef BRANCH_STATS_EN
    check32("stat_branches_cum", stat_branches, exp_br);
    check32("stat_mispredicts_cum", stat_mispredicts, exp_mp);
    do_reset(1'b0);
    issue(1, 3'b000, 32'h600, 32'h10, 0, 32'd3, 32'd3, 1'b1);
    issue(1, 3'b101, 32'h610, 32'h10, 0, 32'd1, 32'd9, 1'b0);
    issue(1, 3'b100, 32'h620, 32'h10, 0, 32'd1, 32'd9, 1'b0);
    drain();
    check32("stat_branches_3", stat_branches, 32'd3);
    check32("stat_mispredicts_1", stat_mispredicts, 32'd1);
`endif

    repeat (3) @(posedge clk);
    check1("queue_empty", exp_q.size() == 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
